booth_multiplier: RTL

BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

---
 rtl/booth_multiplier_pkg.sv | 54 +++++
 rtl/booth_multiplier_cla8.sv | 49 ++++
 rtl/booth_multiplier.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/booth_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// booth_multiplier_pkg
//   Shared definitions for the radix-2 Booth multiplier:
//     - operand width and iteration-counter width
//     - FSM state encodings (IDLE, RUN, DONE)
//     - Booth recoding action type and its decode helper
//     - 4-bit carry-lookahead helper used by the CLA adder
// -----------------------------------------------------------------------------
package booth_multiplier_pkg;

    localparam int WIDTH   = 8;          // operand width
    localparam int PROD_W  = 2 * WIDTH;  // product width
    localparam int COUNT_W = 4;          // iteration counter width (holds 8)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of the bit pair {Q[0], Q_1}.
    function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
        booth_op_t op;
        case ({q0, q_1})
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

    // Flat lookahead carries for a 4-bit group.
    // Returns {c4, c3, c2, c1, c0}; c0 is the incoming carry.
    function automatic logic [4:0] cla4_carries(input logic [3:0] g,
                                                input logic [3:0] p,
                                                input logic       c0);
        logic c1, c2, c3, c4;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, c3, c2, c1, c0};
    endfunction

endpackage

// File: rtl/booth_multiplier_cla8.sv
// -----------------------------------------------------------------------------
// booth_multiplier_cla8
//   8-bit carry-lookahead adder built from two 4-bit lookahead groups.
//   Ports:
//     a, b  : in  [7:0]  addends
//     cin   : in         carry in (1 for two's-complement subtract)
//     sum   : out [7:0]  a + b + cin (modulo 256)
//     cout  : out        carry out of bit 7
// -----------------------------------------------------------------------------
module booth_multiplier_cla8
    import booth_multiplier_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [4:0]       carry_lo;
    logic [4:0]       carry_hi;
    logic [WIDTH-1:0] carry_in;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_gp
            assign gen[gi]  = a[gi] & b[gi];
            assign prop[gi] = a[gi] ^ b[gi];
        end
    endgenerate

    // Separate carry vectors per group keep the lookahead free of
    // combinational self-reference inside a single vector.
    assign carry_lo = cla4_carries(gen[3:0], prop[3:0], cin);
    assign carry_hi = cla4_carries(gen[7:4], prop[7:4], carry_lo[4]);

    assign carry_in = {carry_hi[3:0], carry_lo[3:0]};

    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_sum
            assign sum[gi] = prop[gi] ^ carry_in[gi];
        end
    endgenerate

    assign cout = carry_hi[4];

endmodule

// File: rtl/booth_multiplier.sv
// -----------------------------------------------------------------------------
// booth_multiplier
//   Sequential radix-2 Booth multiplier, 8x8 signed -> 16-bit signed.
//   One Booth step per clock: 8 RUN cycles, then one DONE cycle.
//   Ports:
//     clk     : in         clock, rising edge
//     rst     : in         synchronous active-high reset
//     start   : in         begin a multiply (sampled only in IDLE)
//     A       : in  [7:0]  multiplicand, two's complement
//     B       : in  [7:0]  multiplier, two's complement
//     product : out [15:0] registered signed product, held until next DONE
//     busy    : out        high in RUN and DONE
//     done    : out        one-cycle pulse, product valid
// -----------------------------------------------------------------------------
module booth_multiplier
    import booth_multiplier_pkg::*;
#(
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    output logic [PROD_W-1:0] product,
    output logic              busy,
    output logic              done
);

    state_t              state_q,   state_d;
    logic [WIDTH-1:0]    m_q,       m_d;
    logic [WIDTH-1:0]    acc_q,     acc_d;
    logic [WIDTH-1:0]    q_q,       q_d;
    logic                q_1_q,     q_1_d;
    logic [COUNT_W-1:0]  count_q,   count_d;
    logic [PROD_W-1:0]   product_q, product_d;

    booth_op_t           op;
    logic [WIDTH-1:0]    add_b;
    logic                add_cin;
    logic [WIDTH-1:0]    add_sum;
    logic                add_cout;
    logic [WIDTH-1:0]    step_res;
    logic                step_sign;

    // ------------------------------------------------------------------
    // Booth action selection and the single shared adder.
    // Subtract is M's one's complement with carry-in 1.
    // ------------------------------------------------------------------
    assign op      = booth_decode(q_q[0], q_1_q);
    assign add_b   = (op == OP_SUB) ? ~m_q : m_q;
    assign add_cin = (op == OP_SUB);

    booth_multiplier_cla8 u_cla8 (
        .a    (acc_q),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Result of the current step before the arithmetic shift.
    // The shifted-in bit is the true 9th (sign) bit of ACC +/- M, so
    // M = -128 cannot corrupt the sign even when the 8-bit sum wraps.
    always_comb begin
        step_res  = acc_q;
        step_sign = acc_q[WIDTH-1];
        if (op != OP_NOP) begin
            step_res  = add_sum;
            step_sign = acc_q[WIDTH-1] ^ add_b[WIDTH-1] ^ add_cout;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        q_1_d     = q_1_q;
        count_d   = count_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = A;
                    acc_d   = '0;
                    q_d     = B;
                    q_1_d   = 1'b0;
                    count_d = COUNT_W'(N);
                    state_d = RUN;
                end
            end

            RUN: begin
                // Arithmetic right shift of {ACC, Q, Q_1}.
                acc_d   = {step_sign, step_res[WIDTH-1:1]};
                q_d     = {step_res[0], q_q[WIDTH-1:1]};
                q_1_d   = q_q[0];
                count_d = count_q - COUNT_W'(1);
                if (count_q == COUNT_W'(1)) begin
                    // Last step: capture the final shifted value so it is
                    // on the product port during the DONE cycle.
                    product_d = {acc_d, q_d};
                    state_d   = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            q_1_q     <= 1'b0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            q_1_q     <= q_1_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule
